// File: rtl/kick_pkg.sv
// rtl/kick_pkg.sv - state encoding and default timing constants shared by the kick sequencer
package kick_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_LOW,
        COOLDOWN,
        FAULT
    } kick_state_e;

    localparam int DEF_DEBOUNCE_CYC     = 1_000_000;
    localparam int DEF_COOLDOWN_CYC     = 100_000_000;
    localparam int DEF_FIRE_TIMEOUT_CYC = 50_000_000;
    localparam int DEF_CNT_W            = 27;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kick_sequencer_if.sv
// rtl/kick_sequencer_if.sv - control handshake between nav FSM / kicker and the kick sequencer
interface kick_sequencer_if;

    logic kick_req;
    logic kicker_done;
    logic fault_clr;
    logic kick_en;
    logic kick_ack;
    logic ball_ok;
    logic ready;
    logic fault;

    modport master (
        output kick_req, kicker_done, fault_clr,
        input  kick_en, kick_ack, ball_ok, ready, fault
    );

    modport slave (
        input  kick_req, kicker_done, fault_clr,
        output kick_en, kick_ack, ball_ok, ready, fault
    );

endinterface

// File: rtl/kick_sequencer_ball_debounce.sv
// rtl/kick_sequencer_ball_debounce.sv - 2-FF synchroniser and stability counter for the ball sensor
module ball_debounce
    import kick_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ball_raw,
    output logic ball_ok
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic [DB_W-1:0] cnt_q;

    // cnt_q counts consecutive cycles the synced sensor disagrees with ball_ok;
    // any agreeing cycle restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            ball_ok <= 1'b0;
        end else begin
            sync_q1 <= ball_raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == ball_ok) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_q   <= '0;
                ball_ok <= sync_q2;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kick_sequencer.sv
// rtl/kick_sequencer.sv - kick request/fire/cooldown sequencer; KICK_AUTOFIRE_EN adds ball-edge autofire
module kick_sequencer
    import kick_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int COOLDOWN_CYC     = DEF_COOLDOWN_CYC,
    parameter int FIRE_TIMEOUT_CYC = DEF_FIRE_TIMEOUT_CYC,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ball_raw,
    kick_sequencer_if.slave  kif
);

    localparam int MAX_CNT = max2(COOLDOWN_CYC, FIRE_TIMEOUT_CYC);

    if (CNT_W < $clog2(MAX_CNT + 1)) begin : g_cnt_w_too_small
        $error("kick_sequencer: CNT_W too narrow for the largest timer count");
    end

    localparam logic [CNT_W-1:0] FIRE_LAST = CNT_W'(FIRE_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    kick_state_e      state_q;
    kick_state_e      state_d;
    logic [CNT_W-1:0] timer_q;
    logic             timer_clr;
    logic             done_q;
    logic             done_rise;
    logic             ball_ok;
    logic             kick_go;
    logic             kick_ack_c;

    ball_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_ball_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .ball_raw (ball_raw),
        .ball_ok  (ball_ok)
    );

`ifdef KICK_AUTOFIRE_EN
    logic ball_ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_ok_q <= 1'b0;
        end else begin
            ball_ok_q <= ball_ok;
        end
    end

    assign kick_go = ball_ok & (kif.kick_req | ~ball_ok_q);
`else
    assign kick_go = ball_ok & kif.kick_req;
`endif

    // done_q follows kicker_done in every state, so a level already high at FIRE entry is never an edge.
    assign done_rise = kif.kicker_done & ~done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= kif.kicker_done;
            if (timer_clr) begin
                timer_q <= '0;
            end else if (timer_q != CNT_MAX) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_clr  = 1'b0;
        kick_ack_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (kick_go) begin
                    state_d    = FIRE;
                    timer_clr  = 1'b1;
                    kick_ack_c = 1'b1;
                end
            end
            FIRE: begin
                // a completion edge beats a timeout landing in the same cycle
                if (done_rise) begin
                    state_d   = COOLDOWN;
                    timer_clr = 1'b1;
                end else if (timer_q == FIRE_LAST) begin
                    state_d = FAULT;
                end
            end
            COOLDOWN: begin
                if (timer_q == COOL_LAST) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (kif.fault_clr) begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!kif.kicker_done) begin
                    state_d   = COOLDOWN;
                    timer_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign kif.kick_en  = (state_q == FIRE);
    assign kif.kick_ack = kick_ack_c;
    assign kif.ball_ok  = ball_ok;
    assign kif.ready    = (state_q == IDLE) & ball_ok;
    assign kif.fault    = (state_q == FAULT);

endmodule
